subword_mem: RTL and testbench

Parametrised little-endian data memory with byte, halfword and word loads and stores, sign or zero extension, and a sub-word store read-modify-write engine. It replaces the word-only data memory plus separate byte-load fixup stage in the single-cycle core's data path. It is reached through a valid/ready request port, so a multicycle or pipelined core can stall on it.

---
 rtl/subword_mem_pkg.sv | 25 ++
 rtl/subword_extract.sv | 25 ++
 rtl/subword_mem.sv | 150 +++++++++++++++
 tb/tb_subword_mem.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subword_mem_pkg.sv
// rtl/subword_mem_pkg.sv - size encodings, RMW state type and byte-lane mask helper for subword_mem
package subword_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    RMW_IDLE = 2'd0,
    RMW_RD   = 2'd1,
    RMW_WR   = 2'd2
  } rmw_state_t;

  // Halfword lane comes from offset[1] only; size 2'b11 behaves as a word.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << offset;
      SZ_HALF: m = offset[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/subword_extract.sv
// rtl/subword_extract.sv - load-path lane select with sign or zero extension
module subword_extract
  import subword_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = {{24{sext & byte_v[7]}}, byte_v};
      SZ_HALF: result = {{16{sext & half_v[15]}}, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/subword_mem.sv
// rtl/subword_mem.sv - little-endian data memory with byte/half/word access and sub-word RMW stores
// Optional misalignment trap and fault port: SUBWORD_MEM_MISALIGN_TRAP_EN.
module subword_mem
  import subword_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic [31:0]   rdata,
  output logic          rdata_valid
`ifdef SUBWORD_MEM_MISALIGN_TRAP_EN
  ,
  output logic          fault
`endif
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  rmw_state_t    state;

  logic [IW-1:0] req_idx;
  logic          accept;
  logic          misaligned;
  logic          is_word;
  logic          do_load;
  logic          do_wstore;
  logic          do_sstore;

  logic [IW-1:0] rmw_idx;
  logic [3:0]    rmw_mask;
  logic [31:0]   rmw_data;
  logic [31:0]   merge_q;
  logic [31:0]   merged;

  logic [31:0]   ld_word;
  logic [1:0]    ld_size;
  logic [1:0]    ld_lane;
  logic          ld_sext;

  logic          mem_we;
  logic [IW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  // Upper address bits are dropped on purpose: accesses wrap modulo DEPTH words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[AW-1:IW+2];

  assign req_idx   = req_addr[2 +: IW];
  assign req_ready = (state == RMW_IDLE);
  assign accept    = req_valid && req_ready;
  assign is_word   = req_size[1];

`ifdef SUBWORD_MEM_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign do_load   = accept && !req_we && !misaligned;
  assign do_wstore = accept &&  req_we &&  is_word && !misaligned;
  assign do_sstore = accept &&  req_we && !is_word && !misaligned;

  always_comb begin
    merged = merge_q;
    for (int i = 0; i < 4; i++) begin
      if (rmw_mask[i]) merged[8*i +: 8] = rmw_data[8*i +: 8];
    end
  end

  // Reset gates the write so an RMW interrupted in RMW_WR leaves memory untouched.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = req_idx;
    mem_wdata = req_wdata;
    if (!reset) begin
      if (state == RMW_WR) begin
        mem_we    = 1'b1;
        mem_widx  = rmw_idx;
        mem_wdata = merged;
      end else if (do_wstore) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
    if (state == RMW_RD) merge_q <= mem[rmw_idx];
  end

  always_ff @(posedge clk) begin
    if (do_sstore) begin
      rmw_idx  <= req_idx;
      rmw_mask <= lane_mask(req_size, req_addr[1:0]);
      rmw_data <= (req_size == SZ_HALF) ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RMW_IDLE;
      rdata_valid <= 1'b0;
      ld_word     <= 32'd0;
      ld_size     <= SZ_WORD;
      ld_lane     <= 2'b00;
      ld_sext     <= 1'b0;
    end else begin
      rdata_valid <= do_load;
      if (do_load) begin
        ld_word <= mem[req_idx];
        ld_size <= req_size;
        ld_lane <= req_addr[1:0];
        ld_sext <= req_signed;
      end
      case (state)
        RMW_IDLE: if (do_sstore) state <= RMW_RD;
        RMW_RD:   state <= RMW_WR;
        RMW_WR:   state <= RMW_IDLE;
        default:  state <= RMW_IDLE;
      endcase
    end
  end

`ifdef SUBWORD_MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) fault <= 1'b0;
    else       fault <= accept && misaligned;
  end
`endif

  subword_extract u_extract (
    .word   (ld_word),
    .size   (ld_size),
    .lane   (ld_lane),
    .sext   (ld_sext),
    .result (rdata)
  );

endmodule

// File: tb/tb_subword_mem.sv
// tb/tb_subword_mem.sv - self-checking bench for subword_mem against a byte-array reference model
module tb_subword_mem;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
`ifdef SUBWORD_MEM_MISALIGN_TRAP_EN
  logic        fault;
`endif

  int compared = 0;
  int mismatched = 0;

  logic [7:0] ref_bytes [NBYTES];

  always #5 clk = ~clk;

  subword_mem #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid)
`ifdef SUBWORD_MEM_MISALIGN_TRAP_EN
    ,
    .fault       (fault)
`endif
  );

  function automatic int eff_addr(input logic [31:0] addr, input logic [1:0] sz);
    int a;
    a = int'(addr % NBYTES);
    if (sz == 2'b01) a = a - (a % 2);
    else if (sz[1]) a = a - (a % 4);
    return a;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input bit sg);
    int a;
    int v;
    a = eff_addr(addr, sz);
    if (sz == 2'b00) begin
      v = ref_bytes[a];
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'b01) begin
      v = ref_bytes[a] + 256 * ref_bytes[a+1];
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
    end
    return 32'(v);
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    int a;
    int n;
    a = eff_addr(addr, sz);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_bytes[a+i] = wd[8*i +: 8];
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    int guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("FAIL issue_ready_timeout got=%b want=1", req_ready);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    issue(1'b1, sz, 1'b0, addr, wd);
    model_store(addr, sz, wd);
  endtask

  task automatic load_check(input string name, input logic [1:0] sz, input bit sg,
                            input logic [31:0] addr, input logic [31:0] want);
    issue(1'b0, sz, sg, addr, 32'd0);
    compared++;
    if (rdata_valid !== 1'b1 || rdata !== want) begin
      mismatched++;
      $display("FAIL %s addr=%h valid=%b got=%h want=%h", name, addr, rdata_valid, rdata, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1 || rdata_valid !== 1'b0 || rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_state ready=%b valid=%b rdata=%h want 1/0/00000000", req_ready, rdata_valid, rdata);
    end
  endtask

  task automatic test_init;
    for (int i = 0; i < DEPTH; i++) store(2'b10, 32'(i * 4), $urandom);
  endtask

  task automatic test_sign_ext;
    store(2'b10, 32'h10, 32'hDEADBEEF);
    load_check("byte_signed", 2'b00, 1'b1, 32'h13, 32'hFFFFFFDE);
    load_check("byte_unsigned", 2'b00, 1'b0, 32'h13, 32'h000000DE);
  endtask

  task automatic test_byte_rmw;
    store(2'b00, 32'h12, 32'h00000055);
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rmw_stall_c1 ready=%b want 0", req_ready);
    end
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rmw_stall_c2 ready=%b want 0", req_ready);
    end
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rmw_done ready=%b want 1", req_ready);
    end
    load_check("byte_rmw_word", 2'b10, 1'b0, 32'h10, 32'hDE55BEEF);
  endtask

  task automatic test_half;
    store(2'b01, 32'h22, 32'h00008001);
    load_check("half_signed", 2'b01, 1'b1, 32'h22, 32'hFFFF8001);
    load_check("half_unsigned", 2'b01, 1'b0, 32'h22, 32'h00008001);
  endtask

  task automatic test_reset_rmw;
    store(2'b10, 32'h30, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h000000AA);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1 || rdata_valid !== 1'b0 || rdata !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_in_rmw ready=%b valid=%b rdata=%h want 1/0/00000000", req_ready, rdata_valid, rdata);
    end
    load_check("rmw_abandoned", 2'b10, 1'b0, 32'h30, 32'h11223344);
  endtask

  task automatic test_alias;
    store(2'b10, 32'h100, 32'h12345678);
    load_check("alias_wrap", 2'b10, 1'b0, 32'h0, 32'h12345678);
  endtask

  task automatic test_write_first;
    logic [31:0] v;
    v = $urandom;
    store(2'b10, 32'h40, v);
    load_check("write_first", 2'b10, 1'b0, 32'h40, v);
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    logic [31:0] want;
    for (int i = 0; i < 4; i++) addrs[i] = 32'($urandom_range(0, DEPTH - 1) * 4);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        want = model_load(addrs[i-1], 2'b10, 1'b0);
        compared++;
        if (rdata_valid !== 1'b1 || rdata !== want) begin
          mismatched++;
          $display("FAIL back_to_back[%0d] valid=%b got=%h want=%h", i - 1, rdata_valid, rdata, want);
        end
      end
      if (i < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = addrs[i];
        @(negedge clk);
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    compared++;
    if (rdata_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_pulse_end valid=%b want 0", rdata_valid);
    end
  endtask

  task automatic test_misalign;
    store(2'b10, 32'h04, 32'hCAFEF00D);
`ifdef SUBWORD_MEM_MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'd0);
    compared++;
    if (fault !== 1'b1 || rdata_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL misalign_fault fault=%b valid=%b want 1/0", fault, rdata_valid);
    end
    issue(1'b1, 2'b10, 1'b0, 32'h06, 32'h0BADBAD0);
    load_check("misalign_nowrite", 2'b10, 1'b0, 32'h04, 32'hCAFEF00D);
    compared++;
    if (fault !== 1'b0) begin
      mismatched++;
      $display("FAIL fault_pulse fault=%b want 0", fault);
    end
`else
    load_check("misalign_word", 2'b10, 1'b0, 32'h06, 32'hCAFEF00D);
    load_check("misalign_half", 2'b01, 1'b0, 32'h05, 32'h0000F00D);
`endif
  endtask

  task automatic test_random;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          sg;
    for (int n = 0; n < 300; n++) begin
      sz   = 2'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 2 * NBYTES - 1));
      wd   = $urandom;
`ifdef SUBWORD_MEM_MISALIGN_TRAP_EN
      addr = 32'(eff_addr(addr, sz)) + (addr & ~32'(NBYTES - 1));
`endif
      if ($urandom_range(0, 1) == 1) store(sz, addr, wd);
      else load_check("random_load", sz, sg, addr, model_load(addr, sz, sg));
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_sign_ext();
    test_byte_rmw();
    test_half();
    test_reset_rmw();
    test_alias();
    test_write_first();
    test_back_to_back();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
